clk_freq_div: RTL and testbench
===============================

Name: clk_freq_div

Overview:
- Derives a slow, roughly 50%-duty clock-enable-style square wave o_clk from the fast system clock i_clk.
- Typical use: UART baud clock, e.g. 115200 Hz from 50 MHz.
- Uses a fractional (Bresenham/phase) accumulator, so the long-run output frequency is exact even when p_input_freq/(2*p_output_freq) is not an integer.
- o_clk is a registered logic signal in the i_clk domain, not a true clock net. Consumers should prefer o_tick as an enable.

Parameters:
- p_input_freq, 50_000_000, i_clk frequency in Hz (integer > 0).
- p_output_freq, 115_200, desired o_clk frequency in Hz (integer > 0, 2*p_output_freq <= p_input_freq).

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- o_clk  output 1  divided square wave.
- o_tick output 1  one-i_clk-cycle pulse, high in the cycle after each o_clk rising toggle (same edge that sets o_clk=1).

Behaviour:
- Elaboration checks: $error if p_output_freq == 0, p_input_freq == 0, or 2*p_output_freq > p_input_freq.
- Constants:
  - INC = 2*p_output_freq
  - MOD = p_input_freq
  - ACC_W = $clog2(MOD + INC) + 1
  - All arithmetic is unsigned at ACC_W bits; no overflow is possible.
- State: acc[ACC_W-1:0], o_clk register, o_tick register.
- Reset, asynchronous while i_rst=1: acc=0, o_clk=0, o_tick=0. Reset asserted mid-operation clears everything immediately, regardless of i_clk.
- Each i_clk rising edge with i_rst=0:
  - sum = acc + INC.
  - If sum >= MOD: acc <= sum - MOD, o_clk <= ~o_clk, o_tick <= ~o_clk (i.e. 1 only when toggling 0->1).
  - Else: acc <= sum, o_tick <= 0.
- Timing:
  - Each half-period is floor(MOD/INC) or ceil(MOD/INC) i_clk cycles.
  - Over any MOD consecutive cycles there are exactly INC toggles.
  - First toggle after reset release occurs on edge number ceil(MOD/INC). Default: 218th edge; half-periods are 217 or 218 cycles (average 217.014).
- Boundaries:
  - INC == MOD: o_clk toggles every edge (divide-by-2); acc stays 0.
  - MOD an exact multiple of INC: constant half-period MOD/INC; acc returns to 0 at each toggle.
- Duty cycle: high and low phases differ by at most one i_clk cycle.
- Latency: o_clk and o_tick are registered outputs with no combinational path from inputs.

Decomposition:
- Package clk_freq_div_pkg contains:
  - function acc_width(input_freq, output_freq) returning ACC_W.
  - function half_period_min(input_freq, output_freq) for benches and assertions.
- No sub-module: single module with one accumulator and one toggle flop.
- Optional SVA in the same file: o_tick implies $rose(o_clk); half-period within [floor, ceil].

Test Plan:
- Default params, 20 ns i_clk, reset pulse of 2 cycles:
  - o_clk=0 and o_tick=0 during reset.
  - First o_clk rise on the 218th edge after release.
  - Every half-period is 217 or 218 cycles.
  - Measured freq for 10 pulses is within 115200 ±0.5%.
- p_input_freq=50_000_000, p_output_freq=1_000_000 -> constant half-period 25 cycles, 50% duty, acc=0 at each toggle.
- p_input_freq=1000, p_output_freq=3 -> over exactly 1000 cycles after reset: 6 toggles, 3 o_tick pulses; acc=0 and o_clk=0 after cycle 1000.
- p_input_freq=p_output_freq*2 (e.g. 100/50) -> o_clk toggles every edge; o_tick high every other cycle.
- Assert i_rst asynchronously mid-high-phase (between i_clk edges) -> o_clk, o_tick, acc go to 0 immediately. After release, the first toggle again occurs after ceil(MOD/INC) edges.
- Every o_tick pulse is exactly one cycle wide and coincides with the cycle in which o_clk has just risen; no o_tick occurs on falling toggles.

Source files
------------

// File: rtl/clk_freq_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_freq_div_pkg
// Sizing helpers shared by the fractional clock divider and its benches.
//   acc_width       : phase accumulator width for a given frequency pair
//   half_period_min : shortest o_clk half-period in input clock cycles
//   half_period_max : longest o_clk half-period in input clock cycles
//   cnt_width       : width of a counter able to hold half_period_max
// ---------------------------------------------------------------------------
package clk_freq_div_pkg;

    // Accumulator must hold acc + INC, which is always below MOD + INC.
    function automatic int unsigned acc_width(input int unsigned input_freq,
                                              input int unsigned output_freq);
        return unsigned'($clog2(input_freq + 2 * output_freq)) + 32'd1;
    endfunction

    // floor(MOD / INC)
    function automatic int unsigned half_period_min(input int unsigned input_freq,
                                                    input int unsigned output_freq);
        return input_freq / (2 * output_freq);
    endfunction

    // ceil(MOD / INC)
    function automatic int unsigned half_period_max(input int unsigned input_freq,
                                                    input int unsigned output_freq);
        return (input_freq + 2 * output_freq - 32'd1) / (2 * output_freq);
    endfunction

    // Counter width covering 0 .. half_period_max
    function automatic int unsigned cnt_width(input int unsigned input_freq,
                                              input int unsigned output_freq);
        return unsigned'($clog2(half_period_max(input_freq, output_freq) + 32'd1)) + 32'd1;
    endfunction

endpackage : clk_freq_div_pkg

// File: rtl/clk_freq_div.sv
// ---------------------------------------------------------------------------
// clk_freq_div
// Fractional (phase accumulator) divider producing a ~50% duty square wave
// o_clk in the i_clk domain. The accumulator advances by 2*p_output_freq per
// cycle and wraps modulo p_input_freq; each wrap toggles o_clk, so the long
// run frequency is exact even for non-integer division ratios.
//
// Ports
//   i_clk  : system clock, all logic on the rising edge
//   i_rst  : asynchronous active-high reset
//   o_clk  : divided square wave (registered logic signal, not a clock net)
//   o_tick : one-cycle pulse in the cycle after each rising toggle of o_clk;
//            intended as the clock enable for downstream logic
// ---------------------------------------------------------------------------
module clk_freq_div
    import clk_freq_div_pkg::*;
#(
    parameter int unsigned p_input_freq  = 50_000_000,
    parameter int unsigned p_output_freq = 115_200
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_clk,
    output logic o_tick
);

    localparam int unsigned INC_VAL = 2 * p_output_freq;
    localparam int unsigned ACC_W   = acc_width(p_input_freq, p_output_freq);
    localparam int unsigned HP_MIN  = half_period_min(p_input_freq, p_output_freq);
    localparam int unsigned HP_MAX  = half_period_max(p_input_freq, p_output_freq);
    localparam int unsigned HP_W    = cnt_width(p_input_freq, p_output_freq);

    localparam logic [ACC_W-1:0] INC = ACC_W'(INC_VAL);
    localparam logic [ACC_W-1:0] MOD = ACC_W'(p_input_freq);

    // Half-period bounds expressed as "cycles since last toggle" minus one.
    localparam logic [HP_W-1:0] HP_MIN_M1 = HP_W'(HP_MIN - 32'd1);
    localparam logic [HP_W-1:0] HP_MAX_M1 = HP_W'(HP_MAX - 32'd1);

    // Parameter sanity checks at elaboration
    if (p_output_freq == 0) begin : g_err_out_zero
        $error("clk_freq_div: p_output_freq must be greater than zero");
    end
    if (p_input_freq == 0) begin : g_err_in_zero
        $error("clk_freq_div: p_input_freq must be greater than zero");
    end
    if (2 * p_output_freq > p_input_freq) begin : g_err_ratio
        $error("clk_freq_div: 2*p_output_freq must not exceed p_input_freq");
    end

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum_c;
    logic             wrap_c;

    // Next phase and wrap detection; acc < MOD always, so sum cannot overflow.
    always_comb begin
        sum_c  = acc + INC;
        wrap_c = (sum_c >= MOD);
    end

    // Phase accumulator plus toggle and tick flops
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc    <= '0;
            o_clk  <= 1'b0;
            o_tick <= 1'b0;
        end else if (wrap_c) begin
            acc    <= sum_c - MOD;
            o_clk  <= ~o_clk;
            // Tick only on the 0->1 toggle
            o_tick <= ~o_clk;
        end else begin
            acc    <= sum_c;
            o_tick <= 1'b0;
        end
    end

    // Cycles elapsed since the last toggle (or since reset release)
    logic [HP_W-1:0] hp_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hp_cnt <= '0;
        end else if (wrap_c) begin
            hp_cnt <= '0;
        end else begin
            hp_cnt <= hp_cnt + HP_W'(1);
        end
    end

    // A tick always accompanies a freshly risen o_clk
    a_tick_on_rise : assert property (@(posedge i_clk) disable iff (i_rst)
        o_tick |-> $rose(o_clk));

    // Every half-period lies in [floor(MOD/INC), ceil(MOD/INC)]
    a_half_period_range : assert property (@(posedge i_clk) disable iff (i_rst)
        wrap_c |-> (hp_cnt >= HP_MIN_M1) && (hp_cnt <= HP_MAX_M1));

    a_half_period_bound : assert property (@(posedge i_clk) disable iff (i_rst)
        hp_cnt <= HP_MAX_M1);

endmodule : clk_freq_div

// File: tb/tb_clk_freq_div.sv
// ---------------------------------------------------------------------------
// tb_clk_freq_div
// Four divider instances (default UART ratio, integer ratio, coarse fractional
// ratio, divide-by-2) share one clock and reset. A reference built from the
// toggle-count rule (toggles after k edges = floor(k*INC/MOD)) predicts every
// output each cycle; random run lengths and random mid-cycle async resets
// exercise restart behaviour.
// ---------------------------------------------------------------------------
module tb_clk_freq_div;

    localparam int unsigned DEF_IN  = 50_000_000;
    localparam int unsigned DEF_OUT = 115_200;
    localparam int unsigned INT_IN  = 50_000_000;
    localparam int unsigned INT_OUT = 1_000_000;
    localparam int unsigned FRC_IN  = 1000;
    localparam int unsigned FRC_OUT = 3;
    localparam int unsigned DV2_IN  = 100;
    localparam int unsigned DV2_OUT = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic def_clk, def_tick;
    logic int_clk, int_tick;
    logic frc_clk, frc_tick;
    logic dv2_clk, dv2_tick;

    always #10 clk = ~clk;

    clk_freq_div #(.p_input_freq(DEF_IN), .p_output_freq(DEF_OUT)) u_def (
        .i_clk(clk), .i_rst(rst), .o_clk(def_clk), .o_tick(def_tick));
    clk_freq_div #(.p_input_freq(INT_IN), .p_output_freq(INT_OUT)) u_int (
        .i_clk(clk), .i_rst(rst), .o_clk(int_clk), .o_tick(int_tick));
    clk_freq_div #(.p_input_freq(FRC_IN), .p_output_freq(FRC_OUT)) u_frc (
        .i_clk(clk), .i_rst(rst), .o_clk(frc_clk), .o_tick(frc_tick));
    clk_freq_div #(.p_input_freq(DV2_IN), .p_output_freq(DV2_OUT)) u_dv2 (
        .i_clk(clk), .i_rst(rst), .o_clk(dv2_clk), .o_tick(dv2_tick));

    int total = 0;
    int bad   = 0;

    longint unsigned n = 0;          // rising edges since reset release
    logic            def_prev = 1'b0;
    logic            def_have_tog = 1'b0;
    longint unsigned def_last_tog = 0;
    longint unsigned def_ticks[$];
    logic            frc_prev = 1'b0;
    int              frc_tog = 0;
    int              frc_ticks = 0;

    // Number of toggles after k edges
    function automatic longint unsigned toggles(input longint unsigned k,
                                                input longint unsigned inc,
                                                input longint unsigned md);
        return (k * inc) / md;
    endfunction

    function automatic logic exp_clk(input longint unsigned k,
                                     input longint unsigned inc,
                                     input longint unsigned md);
        return (toggles(k, inc, md) % 2) == 1;
    endfunction

    function automatic logic exp_tick(input longint unsigned k,
                                      input longint unsigned inc,
                                      input longint unsigned md);
        if (k == 0) return 1'b0;
        return (toggles(k, inc, md) != toggles(k - 1, inc, md)) &&
               ((toggles(k, inc, md) % 2) == 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input string name, input logic oc, input logic ot,
                              input logic [63:0] acc,
                              input longint unsigned inc, input longint unsigned md);
        check({name, "_clk"},  64'(oc),  64'(exp_clk(n, inc, md)));
        check({name, "_tick"}, 64'(ot),  64'(exp_tick(n, inc, md)));
        check({name, "_acc"},  acc,      (n * inc) % md);
    endtask

    // One rising edge, then compare everything 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
        if (!rst) n++;
        check_inst("def", def_clk, def_tick, 64'(u_def.acc), 2 * DEF_OUT, DEF_IN);
        check_inst("int", int_clk, int_tick, 64'(u_int.acc), 2 * INT_OUT, INT_IN);
        check_inst("frc", frc_clk, frc_tick, 64'(u_frc.acc), 2 * FRC_OUT, FRC_IN);
        check_inst("dv2", dv2_clk, dv2_tick, 64'(u_dv2.acc), 2 * DV2_OUT, DV2_IN);
        if (def_clk !== def_prev) begin
            if (def_have_tog)
                check("def_half_period_217_218",
                      64'(((n - def_last_tog) == 217) || ((n - def_last_tog) == 218)), 64'd1);
            else
                check("def_first_rise_edge", n, 64'd218);
            def_have_tog = 1'b1;
            def_last_tog = n;
        end
        def_prev = def_clk;
        if (def_tick === 1'b1) def_ticks.push_back(n);
        if (frc_clk !== frc_prev) frc_tog++;
        frc_prev = frc_clk;
        if (frc_tick === 1'b1) frc_ticks++;
    endtask

    task automatic clear_tracking();
        n            = 0;
        def_prev     = 1'b0;
        def_have_tog = 1'b0;
        def_last_tog = 0;
        def_ticks.delete();
        frc_prev     = 1'b0;
        frc_tog      = 0;
        frc_ticks    = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_def_clk"},  64'(def_clk),  64'd0);
        check({tag, "_def_tick"}, 64'(def_tick), 64'd0);
        check({tag, "_def_acc"},  64'(u_def.acc), 64'd0);
        check({tag, "_frc_clk"},  64'(frc_clk),  64'd0);
        check({tag, "_frc_acc"},  64'(u_frc.acc), 64'd0);
        check({tag, "_dv2_clk"},  64'(dv2_clk),  64'd0);
        check({tag, "_dv2_tick"}, 64'(dv2_tick), 64'd0);
    endtask

    // Reach the default instance's high phase, then reset between clock edges
    task automatic async_reset_mid_high();
        int unsigned guard = 0;
        int unsigned extra;
        while (def_clk !== 1'b1 && guard < 600) begin
            step();
            guard++;
        end
        check("reach_def_high_phase", 64'(def_clk), 64'd1);
        extra = $urandom_range(0, 150);
        while (extra > 0 && def_clk === 1'b1) begin
            step();
            extra--;
        end
        #($urandom_range(2, 8));
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        clear_tracking();
        repeat ($urandom_range(1, 3)) step();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Power-on reset for two cycles
        rst = 1'b1;
        repeat (2) step();
        check_all_zero("por");
        @(negedge clk);
        rst = 1'b0;
        clear_tracking();

        // First 1000 cycles: 1000/3 instance completes exactly one window
        repeat (1000) step();
        check("frc_toggles_in_1000", 64'(frc_tog),   64'd6);
        check("frc_ticks_in_1000",   64'(frc_ticks), 64'd3);
        check("frc_acc_at_1000",     64'(u_frc.acc), 64'd0);
        check("frc_clk_at_1000",     64'(frc_clk),   64'd0);

        // Random run lengths interleaved with asynchronous resets
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(200, 2500)) step();
            async_reset_mid_high();
        end

        // Frequency over ten full periods of the default instance
        clear_tracking();
        repeat (4700) step();
        check("def_tick_count_ge_11", 64'(def_ticks.size() >= 11), 64'd1);
        if (def_ticks.size() >= 11)
            check("def_10_period_span_within_0p5pct",
                  64'(((def_ticks[10] - def_ticks[0]) >= 4319) &&
                      ((def_ticks[10] - def_ticks[0]) <= 4362)), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_clk_freq_div
